// File: rtl/alu_seq_pkg.sv
// Shared definitions for the sequential ALU: op codes, flag bit positions and the
// shifter FSM state type.
package alu_seq_pkg;

   localparam logic [3:0] OP_ADD  = 4'd0;
   localparam logic [3:0] OP_ADDU = 4'd1;
   localparam logic [3:0] OP_ADDC = 4'd2;
   localparam logic [3:0] OP_SUB  = 4'd3;
   localparam logic [3:0] OP_CMP  = 4'd4;
   localparam logic [3:0] OP_AND  = 4'd5;
   localparam logic [3:0] OP_OR   = 4'd6;
   localparam logic [3:0] OP_XOR  = 4'd7;
   localparam logic [3:0] OP_NOT  = 4'd8;
   localparam logic [3:0] OP_MOV  = 4'd9;
   localparam logic [3:0] OP_LSH  = 4'd10;
   localparam logic [3:0] OP_ASH  = 4'd11;

   localparam int FLG_C = 4;
   localparam int FLG_L = 3;
   localparam int FLG_F = 2;
   localparam int FLG_Z = 1;
   localparam int FLG_N = 0;

   typedef enum logic {
      IDLE  = 1'b0,
      SHIFT = 1'b1
   } state_e;

   function automatic logic is_shift(input logic [3:0] op);
      return (op == OP_LSH) || (op == OP_ASH);
   endfunction

endpackage

// File: rtl/alu_seq_if.sv
// Decode-to-writeback bus of the sequential ALU: request and result handshakes plus
// the direct flag-register write port.
interface alu_seq_if #(
   parameter int WIDTH = 16
);
   logic             in_valid;
   logic             in_ready;
   logic [3:0]       op;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] result;
   logic [4:0]       flags;
   logic             flags_we;
   logic [4:0]       flags_in;

   modport master (
      output in_valid, op, a, b, out_ready, flags_we, flags_in,
      input  in_ready, out_valid, result, flags
   );

   modport slave (
      input  in_valid, op, a, b, out_ready, flags_we, flags_in,
      output in_ready, out_valid, result, flags
   );
endinterface

// File: rtl/alu_seq_shifter.sv
// Shift unit for LSH/ASH: a one-cycle barrel shifter, or (SERIAL_SHIFT=1) an iterative
// shifter that moves one bit per cycle and reports busy while it works.
module alu_seq_shifter
   import alu_seq_pkg::*;
#(
   parameter int WIDTH        = 16,
   parameter int SERIAL_SHIFT = 0,
   parameter int SHW          = $clog2(WIDTH) + 1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start_i,
   input  logic             arith_i,
   input  logic [WIDTH-1:0] a_i,
   input  logic [SHW-1:0]   amt_i,
   output logic             busy_o,
   output logic             done_o,
   output logic [WIDTH-1:0] res_o
);

   localparam logic [SHW-1:0] WIDTH_L = SHW'(WIDTH);

   logic                    neg;
   logic [SHW-1:0]          mag;
   logic [SHW-1:0]          capped;
   logic signed [WIDTH-1:0] a_s;
   logic signed [WIDTH-1:0] sra;
   logic [WIDTH-1:0]        barrel;
   logic [WIDTH-1:0]        step;

   state_e           state_q, state_d;
   logic [WIDTH-1:0] work_q, work_d;
   logic [SHW-1:0]   cnt_q, cnt_d;
   logic             right_q, right_d;
   logic             arith_q, arith_d;

   // Negative amounts shift right; any magnitude of WIDTH or more empties the word.
   always_comb begin
      neg    = amt_i[SHW-1];
      mag    = neg ? (~amt_i + SHW'(1)) : amt_i;
      capped = (mag > WIDTH_L) ? WIDTH_L : mag;
      a_s    = a_i;
      sra    = a_s >>> mag;
      if (mag >= WIDTH_L) begin
         barrel = (neg && arith_i) ? {WIDTH{a_i[WIDTH-1]}} : '0;
      end else if (!neg) begin
         barrel = a_i << mag;
      end else if (arith_i) begin
         barrel = sra;
      end else begin
         barrel = a_i >> mag;
      end
      step = right_q ? {arith_q & work_q[WIDTH-1], work_q[WIDTH-1:1]}
                     : {work_q[WIDTH-2:0], 1'b0};
   end

   always_comb begin
      state_d = state_q;
      work_d  = work_q;
      cnt_d   = cnt_q;
      right_d = right_q;
      arith_d = arith_q;
      done_o  = 1'b0;
      res_o   = barrel;
      busy_o  = (state_q == SHIFT);
      case (state_q)
         IDLE: begin
            if (start_i) begin
               if (SERIAL_SHIFT == 0) begin
                  done_o = 1'b1;
               end else if (capped == '0) begin
                  done_o = 1'b1;
                  res_o  = a_i;
               end else begin
                  work_d  = a_i;
                  cnt_d   = capped;
                  right_d = neg;
                  arith_d = arith_i;
                  state_d = SHIFT;
               end
            end
         end
         SHIFT: begin
            // The last single-bit step goes straight to the output register.
            work_d = step;
            cnt_d  = cnt_q - SHW'(1);
            if (cnt_q == SHW'(1)) begin
               done_o  = 1'b1;
               res_o   = step;
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         work_q  <= '0;
         cnt_q   <= '0;
         right_q <= 1'b0;
         arith_q <= 1'b0;
      end else begin
         state_q <= state_d;
         work_q  <= work_d;
         cnt_q   <= cnt_d;
         right_q <= right_d;
         arith_q <= arith_d;
      end
   end

endmodule

// File: rtl/alu_seq.sv
// Registered ALU with a persistent CLFZN flag register, valid/ready handshakes on both
// sides and a shift unit that is either single-cycle or iterative.
module alu_seq
   import alu_seq_pkg::*;
#(
   parameter int WIDTH        = 16,
   parameter int SERIAL_SHIFT = 0,
   parameter int SHW          = $clog2(WIDTH) + 1
) (
   input logic       clk,
   input logic       rst_n,
   alu_seq_if.slave  bus
);

   logic [WIDTH-1:0] result_q, result_d;
   logic             out_valid_q, out_valid_d;
   logic [4:0]       flags_q, flags_d;

   logic             in_ready;
   logic             accept;
   logic             shift_op;
   logic             cin;
   logic [WIDTH:0]   sum;
   logic [WIDTH:0]   diff;
   logic [WIDTH-1:0] alu_res;
   logic [4:0]       alu_flags;
   logic             sh_busy;
   logic             sh_done;
   logic [WIDTH-1:0] sh_res;

   alu_seq_shifter #(
      .WIDTH       (WIDTH),
      .SERIAL_SHIFT(SERIAL_SHIFT),
      .SHW         (SHW)
   ) u_shifter (
      .clk    (clk),
      .rst_n  (rst_n),
      .start_i(accept && shift_op),
      .arith_i(bus.op == OP_ASH),
      .a_i    (bus.a),
      .amt_i  (bus.b[SHW-1:0]),
      .busy_o (sh_busy),
      .done_o (sh_done),
      .res_o  (sh_res)
   );

   // Non-shift datapath; flags not touched by an op keep their stored value.
   always_comb begin
      cin       = (bus.op == OP_ADDC) && flags_q[FLG_C];
      sum       = {1'b0, bus.a} + {1'b0, bus.b} + {{WIDTH{1'b0}}, cin};
      diff      = {1'b0, bus.a} - {1'b0, bus.b};
      alu_res   = '0;
      alu_flags = flags_q;
      case (bus.op)
         OP_ADD, OP_ADDC: begin
            alu_res          = sum[WIDTH-1:0];
            alu_flags[FLG_C] = sum[WIDTH];
            alu_flags[FLG_F] = (bus.a[WIDTH-1] == bus.b[WIDTH-1]) &&
                               (sum[WIDTH-1] != bus.a[WIDTH-1]);
            alu_flags[FLG_Z] = (sum[WIDTH-1:0] == '0);
         end
         OP_ADDU: begin
            alu_res          = sum[WIDTH-1:0];
            alu_flags[FLG_C] = sum[WIDTH];
            alu_flags[FLG_Z] = (sum[WIDTH-1:0] == '0);
         end
         OP_SUB: begin
            alu_res          = diff[WIDTH-1:0];
            alu_flags[FLG_C] = diff[WIDTH];
            alu_flags[FLG_F] = (bus.a[WIDTH-1] != bus.b[WIDTH-1]) &&
                               (diff[WIDTH-1] != bus.a[WIDTH-1]);
            alu_flags[FLG_Z] = (diff[WIDTH-1:0] == '0);
         end
         OP_CMP: begin
            alu_res          = bus.a;
            alu_flags[FLG_L] = bus.a < bus.b;
            alu_flags[FLG_N] = $signed(bus.a) < $signed(bus.b);
            alu_flags[FLG_Z] = bus.a == bus.b;
         end
         OP_AND:  alu_res = bus.a & bus.b;
         OP_OR:   alu_res = bus.a | bus.b;
         OP_XOR:  alu_res = bus.a ^ bus.b;
         OP_NOT:  alu_res = ~bus.a;
         OP_MOV:  alu_res = bus.b;
         default: alu_res = '0;
      endcase
   end

   // Output register holds until consumed; a direct flag write overrides any op update.
   always_comb begin
      shift_op    = is_shift(bus.op);
      in_ready    = !sh_busy && (!out_valid_q || bus.out_ready);
      accept      = bus.in_valid && in_ready;
      result_d    = result_q;
      out_valid_d = out_valid_q && !bus.out_ready;
      if (sh_done) begin
         result_d    = sh_res;
         out_valid_d = 1'b1;
      end else if (accept && !shift_op) begin
         result_d    = alu_res;
         out_valid_d = 1'b1;
      end
      flags_d = flags_q;
      if (accept) begin
         flags_d = alu_flags;
      end
      if (bus.flags_we) begin
         flags_d = bus.flags_in;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         result_q    <= '0;
         out_valid_q <= 1'b0;
         flags_q     <= '0;
      end else begin
         result_q    <= result_d;
         out_valid_q <= out_valid_d;
         flags_q     <= flags_d;
      end
   end

   assign bus.in_ready  = in_ready;
   assign bus.out_valid = out_valid_q;
   assign bus.result    = result_q;
   assign bus.flags     = flags_q;

endmodule

// File: tb/tb_alu_seq.sv
// Self-checking bench for alu_seq: a barrel-shift instance (index 0) and an iterative
// shift instance (index 1) driven by directed scenarios and a randomized model run.
module tb_alu_seq;
   import alu_seq_pkg::*;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   int   checks   = 0;
   int   failures = 0;

   always #5 clk = ~clk;

   alu_seq_if #(.WIDTH(16)) if0 ();
   alu_seq_if #(.WIDTH(16)) if1 ();

   alu_seq #(.WIDTH(16), .SERIAL_SHIFT(0)) dut0 (.clk(clk), .rst_n(rst_n), .bus(if0));
   alu_seq #(.WIDTH(16), .SERIAL_SHIFT(1)) dut1 (.clk(clk), .rst_n(rst_n), .bus(if1));

   logic [15:0] res_w   [2];
   logic        valid_w [2];
   logic        ready_w [2];
   logic [4:0]  flags_w [2];

   assign res_w[0]   = if0.result;
   assign res_w[1]   = if1.result;
   assign valid_w[0] = if0.out_valid;
   assign valid_w[1] = if1.out_valid;
   assign ready_w[0] = if0.in_ready;
   assign ready_w[1] = if1.in_ready;
   assign flags_w[0] = if0.flags;
   assign flags_w[1] = if1.flags;

   // Stimulus plumbing shared by the scenarios below.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic applyStimulus(input int d, input logic v, input logic [3:0] op,
                                input logic [15:0] a, input logic [15:0] b);
      if (d == 0) begin
         if0.in_valid = v; if0.op = op; if0.a = a; if0.b = b;
      end else begin
         if1.in_valid = v; if1.op = op; if1.a = a; if1.b = b;
      end
   endtask

   task automatic set_flags_we(input int d, input logic we, input logic [4:0] fin);
      if (d == 0) begin
         if0.flags_we = we; if0.flags_in = fin;
      end else begin
         if1.flags_we = we; if1.flags_in = fin;
      end
   endtask

   task automatic set_out_ready(input int d, input logic r);
      if (d == 0) if0.out_ready = r;
      else        if1.out_ready = r;
   endtask

   task automatic issue(input int d, input logic [3:0] op, input logic [15:0] a,
                        input logic [15:0] b);
      applyStimulus(d, 1'b1, op, a, b);
      tick();
      applyStimulus(d, 1'b0, op, a, b);
   endtask

   // Reference behaviour computed with plain integer arithmetic; lat is the number of
   // extra cycles an iterative shifter needs.
   function automatic void ref_op(input logic [3:0] op, input logic [15:0] a,
                                  input logic [15:0] b, input logic [4:0] fin,
                                  output logic [15:0] r, output logic [4:0] fo,
                                  output int lat);
      int ua, ub, sa, sb, t, st, amt, c;
      ua = int'(a);
      ub = int'(b);
      sa = int'($signed(a));
      sb = int'($signed(b));
      fo  = fin;
      r   = 16'h0;
      lat = 0;
      case (op)
         OP_ADD, OP_ADDU, OP_ADDC: begin
            c  = (op == OP_ADDC) ? int'(fin[FLG_C]) : 0;
            t  = ua + ub + c;
            st = sa + sb + c;
            r  = t[15:0];
            fo[FLG_C] = (t > 65535);
            fo[FLG_Z] = (r == 16'h0);
            if (op != OP_ADDU) fo[FLG_F] = (st > 32767) || (st < -32768);
         end
         OP_SUB: begin
            t  = ua - ub;
            st = sa - sb;
            r  = t[15:0];
            fo[FLG_C] = (ua < ub);
            fo[FLG_F] = (st > 32767) || (st < -32768);
            fo[FLG_Z] = (r == 16'h0);
         end
         OP_CMP: begin
            r = a;
            fo[FLG_L] = (ua < ub);
            fo[FLG_N] = (sa < sb);
            fo[FLG_Z] = (ua == ub);
         end
         OP_AND: r = a & b;
         OP_OR:  r = a | b;
         OP_XOR: r = a ^ b;
         OP_NOT: r = ~a;
         OP_MOV: r = b;
         OP_LSH, OP_ASH: begin
            amt = int'(b[4:0]);
            if (amt >= 16) amt = amt - 32;
            if (amt >= 0) begin
               t   = ua << amt;
               r   = t[15:0];
               lat = amt;
            end else begin
               t   = (op == OP_ASH) ? (sa >>> (-amt)) : (ua >> (-amt));
               r   = t[15:0];
               lat = -amt;
            end
         end
         default: r = 16'h0;
      endcase
   endfunction

   task automatic test_reset();
      for (int d = 0; d < 2; d++) begin
         checks++;
         if (res_w[d] !== 16'h0 || valid_w[d] !== 1'b0 || flags_w[d] !== 5'h0 ||
             ready_w[d] !== 1'b1) begin
            failures++;
            $display("[TB] FAIL reset dut%0d: result=%h valid=%b flags=%b ready=%b, want 0000/0/00000/1",
                     d, res_w[d], valid_w[d], flags_w[d], ready_w[d]);
         end
      end
   endtask

   task automatic test_add();
      issue(0, OP_ADD, 16'h7FFF, 16'h0001);
      checks++;
      if (res_w[0] !== 16'h8000 || valid_w[0] !== 1'b1) begin
         failures++;
         $display("[TB] FAIL add_result: got %h valid=%b, want 8000 valid=1", res_w[0], valid_w[0]);
      end
      checks++;
      if (flags_w[0] !== 5'b00100) begin
         failures++;
         $display("[TB] FAIL add_flags: got %b, want 00100", flags_w[0]);
      end
   endtask

   task automatic test_addc();
      issue(0, OP_ADDU, 16'hFFFF, 16'h0001);
      checks++;
      if (res_w[0] !== 16'h0000 || flags_w[0][FLG_C] !== 1'b1 || flags_w[0][FLG_Z] !== 1'b1) begin
         failures++;
         $display("[TB] FAIL addu: got result=%h flags=%b, want 0000 with C=1 Z=1", res_w[0], flags_w[0]);
      end
      issue(0, OP_ADDC, 16'h0001, 16'h0001);
      checks++;
      if (res_w[0] !== 16'h0003 || flags_w[0] !== 5'b00000) begin
         failures++;
         $display("[TB] FAIL addc: got result=%h flags=%b, want 0003 00000", res_w[0], flags_w[0]);
      end
   endtask

   task automatic test_cmp();
      set_flags_we(0, 1'b1, 5'b10000);
      tick();
      set_flags_we(0, 1'b0, 5'h0);
      issue(0, OP_CMP, 16'h0001, 16'hFFFF);
      checks++;
      if (res_w[0] !== 16'h0001 || flags_w[0] !== 5'b11000) begin
         failures++;
         $display("[TB] FAIL cmp_lt: got result=%h flags=%b, want 0001 11000", res_w[0], flags_w[0]);
      end
      issue(0, OP_CMP, 16'h1234, 16'h1234);
      checks++;
      if (res_w[0] !== 16'h1234 || flags_w[0] !== 5'b10010) begin
         failures++;
         $display("[TB] FAIL cmp_eq: got result=%h flags=%b, want 1234 10010", res_w[0], flags_w[0]);
      end
   endtask

   task automatic test_flags_we();
      set_flags_we(0, 1'b1, 5'h1F);
      issue(0, OP_ADD, 16'h0001, 16'h0001);
      set_flags_we(0, 1'b0, 5'h0);
      checks++;
      if (flags_w[0] !== 5'h1F || res_w[0] !== 16'h0002) begin
         failures++;
         $display("[TB] FAIL flags_we_priority: got flags=%b result=%h, want 11111 0002",
                  flags_w[0], res_w[0]);
      end
   endtask

   task automatic test_back_to_back();
      applyStimulus(0, 1'b1, OP_ADD, 16'h0003, 16'h0004);
      tick();
      set_out_ready(0, 1'b0);
      applyStimulus(0, 1'b1, OP_ADD, 16'h0001, 16'h0001);
      for (int i = 0; i < 4; i++) begin
         tick();
         checks++;
         if (res_w[0] !== 16'h0007 || valid_w[0] !== 1'b1 || ready_w[0] !== 1'b0) begin
            failures++;
            $display("[TB] FAIL hold cycle %0d: result=%h valid=%b ready=%b, want 0007/1/0",
                     i, res_w[0], valid_w[0], ready_w[0]);
         end
      end
      set_out_ready(0, 1'b1);
      applyStimulus(0, 1'b1, OP_ADD, 16'h0010, 16'h0020);
      #1;
      checks++;
      if (ready_w[0] !== 1'b1) begin
         failures++;
         $display("[TB] FAIL release_ready: got %b, want 1", ready_w[0]);
      end
      tick();
      applyStimulus(0, 1'b0, OP_ADD, 16'h0, 16'h0);
      checks++;
      if (res_w[0] !== 16'h0030 || valid_w[0] !== 1'b1) begin
         failures++;
         $display("[TB] FAIL release_load: result=%h valid=%b, want 0030/1", res_w[0], valid_w[0]);
      end
   endtask

   task automatic serial_case(input string name, input logic [3:0] op, input logic [15:0] a,
                              input logic [15:0] b, input logic [15:0] want, input int want_lat);
      int n;
      issue(1, op, a, b);
      n = 0;
      while (!ready_w[1] && n < 40) begin
         tick();
         n++;
      end
      checks++;
      if (n !== want_lat) begin
         failures++;
         $display("[TB] FAIL %s latency: busy %0d cycles, want %0d", name, n, want_lat);
      end
      checks++;
      if (res_w[1] !== want || valid_w[1] !== 1'b1 || flags_w[1] !== 5'h0) begin
         failures++;
         $display("[TB] FAIL %s result: got %h valid=%b flags=%b, want %h/1/00000",
                  name, res_w[1], valid_w[1], flags_w[1], want);
      end
   endtask

   task automatic test_serial_shift();
      serial_case("lsh5",   OP_LSH, 16'h0001, 16'h0005, 16'h0020, 5);
      serial_case("ash_m3", OP_ASH, 16'h8000, 16'hFFFD, 16'hF000, 3);
      serial_case("lsh16",  OP_LSH, 16'h1234, 16'h0010, 16'h0000, 16);
      serial_case("ash16",  OP_ASH, 16'h8421, 16'h0010, 16'hFFFF, 16);
      serial_case("lsh0",   OP_LSH, 16'hBEEF, 16'h0000, 16'hBEEF, 0);
   endtask

   task automatic test_random(input int d);
      logic [4:0]  mflags;
      logic [4:0]  fo;
      logic [15:0] a, b, r;
      logic [3:0]  op;
      int          lat, n;
      mflags = 5'($urandom);
      set_flags_we(d, 1'b1, mflags);
      tick();
      set_flags_we(d, 1'b0, 5'h0);
      for (int i = 0; i < 40; i++) begin
         op = 4'($urandom_range(0, 15));
         a  = 16'($urandom);
         b  = 16'($urandom);
         ref_op(op, a, b, mflags, r, fo, lat);
         mflags = fo;
         if (d == 0) lat = 0;
         issue(d, op, a, b);
         n = 0;
         while (!valid_w[d] && n < 40) begin
            tick();
            n++;
         end
         checks++;
         if (n !== lat) begin
            failures++;
            $display("[TB] FAIL rand dut%0d #%0d latency op=%0d: got %0d, want %0d", d, i, op, n, lat);
         end
         checks++;
         if (res_w[d] !== r || flags_w[d] !== fo) begin
            failures++;
            $display("[TB] FAIL rand dut%0d #%0d op=%0d a=%h b=%h: got %h/%b, want %h/%b",
                     d, i, op, a, b, res_w[d], flags_w[d], r, fo);
         end
      end
   endtask

   task automatic test_reset_mid_shift();
      set_flags_we(1, 1'b1, 5'h1F);
      tick();
      set_flags_we(1, 1'b0, 5'h0);
      issue(1, OP_LSH, 16'h0001, 16'h000A);
      tick();
      tick();
      rst_n = 1'b0;
      #1;
      checks++;
      if (valid_w[1] !== 1'b0 || flags_w[1] !== 5'h0 || res_w[1] !== 16'h0) begin
         failures++;
         $display("[TB] FAIL reset_mid_shift: valid=%b flags=%b result=%h, want 0/00000/0000",
                  valid_w[1], flags_w[1], res_w[1]);
      end
      tick();
      rst_n = 1'b1;
      tick();
      checks++;
      if (ready_w[1] !== 1'b1) begin
         failures++;
         $display("[TB] FAIL ready_after_reset: got %b, want 1", ready_w[1]);
      end
      serial_case("lsh2_post_reset", OP_LSH, 16'h0001, 16'h0002, 16'h0004, 2);
   endtask

   initial begin
      for (int d = 0; d < 2; d++) begin
         applyStimulus(d, 1'b0, OP_ADD, 16'h0, 16'h0);
         set_flags_we(d, 1'b0, 5'h0);
         set_out_ready(d, 1'b1);
      end
      repeat (2) tick();
      rst_n = 1'b1;
      tick();
      test_reset();
      test_add();
      test_addc();
      test_cmp();
      test_flags_we();
      test_back_to_back();
      test_serial_shift();
      test_random(0);
      test_random(1);
      test_reset_mid_shift();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
